// File: rtl/soc_addr_map_cfg_if.sv
// Config register port and lookup handshake bundle for the
// programmable SoC address map.
interface soc_addr_map_cfg_if #(
   parameter int AddrWidth = 64,
   parameter int IdxWidth  = 5
);
   logic                 cfg_req_i;
   logic                 cfg_we_i;
   logic [7:0]           cfg_addr_i;
   logic [63:0]          cfg_wdata_i;
   logic                 cfg_rvalid_o;
   logic [63:0]          cfg_rdata_o;
   logic                 cfg_err_o;
   logic                 req_valid_i;
   logic                 req_ready_o;
   logic [AddrWidth-1:0] req_addr_i;
   logic                 resp_valid_o;
   logic                 resp_ready_i;
   logic [IdxWidth-1:0]  resp_idx_o;
   logic                 resp_hit_o;
   logic [31:0]          miss_cnt_o;

   modport slave (
      input  cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
      input  req_valid_i, req_addr_i, resp_ready_i,
      output cfg_rvalid_o, cfg_rdata_o, cfg_err_o,
      output req_ready_o, resp_valid_o, resp_idx_o,
      output resp_hit_o, miss_cnt_o
   );

   modport master (
      output cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
      output req_valid_i, req_addr_i, resp_ready_i,
      input  cfg_rvalid_o, cfg_rdata_o, cfg_err_o,
      input  req_ready_o, resp_valid_o, resp_idx_o,
      input  resp_hit_o, miss_cnt_o
   );
endinterface

// File: rtl/soc_addr_map_cfg.sv
// Runtime-programmable address map: NumRules base/length rules with
// per-rule lock, one-stage lookup pipeline and saturating miss counter.
module soc_addr_map_cfg #(
   parameter int NumRules   = 16,
   parameter int AddrWidth  = 64,
   parameter int IdxWidth   = 5,
   parameter int NumSlaves  = 14,
   parameter int DefaultIdx = 14
) (
   input logic clk_i,
   input logic rst_i,
   soc_addr_map_cfg_if.slave bus
);
   localparam int RW = (NumRules > 1) ? $clog2(NumRules) : 1;
   localparam logic [8:0] CntOff = 9'(4 * NumRules);

   logic [AddrWidth-1:0] r_base [NumRules];
   logic [AddrWidth-1:0] r_len  [NumRules];
   logic [IdxWidth-1:0]  r_idx  [NumRules];
   logic [NumRules-1:0]  r_valid;
   logic [NumRules-1:0]  r_lock;

   logic                 r_cfg_rvalid;
   logic [63:0]          r_cfg_rdata;
   logic                 r_cfg_err;
   logic                 r_resp_valid;
   logic [IdxWidth-1:0]  r_resp_idx;
   logic                 r_resp_hit;
   logic [31:0]          r_miss_cnt;

   logic [8:0]           w_off9;
   logic                 w_in_rules;
   logic                 w_is_cnt;
   logic [RW-1:0]        w_rule;
   logic [1:0]           w_field;
   logic [IdxWidth-1:0]  w_wr_idx;
   logic                 w_idx_ok;
   logic [63:0]          w_ctrl_rd;
   logic [63:0]          w_rdata;
   logic                 w_err;
   logic                 w_wr_base;
   logic                 w_wr_len;
   logic                 w_wr_ctrl;
   logic                 w_cnt_clr;
   logic                 w_hit;
   logic [IdxWidth-1:0]  w_idx;
   logic                 w_acc;
   logic                 w_miss;

   assign w_off9     = {1'b0, bus.cfg_addr_i};
   assign w_in_rules = w_off9 < CntOff;
   assign w_is_cnt   = w_off9 == CntOff;
   assign w_rule     = bus.cfg_addr_i[RW+1:2];
   assign w_field    = bus.cfg_addr_i[1:0];
   assign w_wr_idx   = bus.cfg_wdata_i[IdxWidth:1];
   assign w_idx_ok   = w_wr_idx < IdxWidth'(NumSlaves);

   always_comb begin
      w_ctrl_rd              = '0;
      w_ctrl_rd[0]           = r_valid[w_rule];
      w_ctrl_rd[IdxWidth:1]  = r_idx[w_rule];
      w_ctrl_rd[31]          = r_lock[w_rule];
   end

   // Register decode; write strobes are only raised for accepted writes.
   always_comb begin
      w_rdata   = '0;
      w_err     = 1'b0;
      w_wr_base = 1'b0;
      w_wr_len  = 1'b0;
      w_wr_ctrl = 1'b0;
      w_cnt_clr = 1'b0;
      if (w_in_rules) begin
         unique case (w_field)
            2'd0:    w_rdata = r_base[w_rule];
            2'd1:    w_rdata = r_len[w_rule];
            2'd2:    w_rdata = w_ctrl_rd;
            default: w_rdata = '0;
         endcase
         if (bus.cfg_we_i) begin
            if (w_field == 2'd3 || r_lock[w_rule]) begin
               w_err = 1'b1;
            end else if (w_field == 2'd2 && !w_idx_ok) begin
               w_err = 1'b1;
            end else begin
               w_wr_base = bus.cfg_req_i && (w_field == 2'd0);
               w_wr_len  = bus.cfg_req_i && (w_field == 2'd1);
               w_wr_ctrl = bus.cfg_req_i && (w_field == 2'd2);
            end
         end
      end else if (w_is_cnt) begin
         w_rdata   = {32'b0, r_miss_cnt};
         w_cnt_clr = bus.cfg_req_i && bus.cfg_we_i;
      end else begin
         w_err = 1'b1;
      end
   end

   // Walk from the top so the lowest matching rule wins.
   always_comb begin : lookup
      logic [AddrWidth-1:0] diff;
      diff  = '0;
      w_hit = 1'b0;
      w_idx = IdxWidth'(DefaultIdx);
      for (int i = NumRules - 1; i >= 0; i--) begin
         diff = bus.req_addr_i - r_base[i];
         if (r_valid[i] && bus.req_addr_i >= r_base[i] && diff < r_len[i]) begin
            w_hit = 1'b1;
            w_idx = r_idx[i];
         end
      end
   end

   assign bus.req_ready_o = !r_resp_valid || bus.resp_ready_i;
   assign w_acc  = bus.req_valid_i && bus.req_ready_o;
   assign w_miss = w_acc && !w_hit;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NumRules; i++) begin
            r_base[i] <= '0;
            r_len[i]  <= '0;
            r_idx[i]  <= '0;
         end
         r_valid      <= '0;
         r_lock       <= '0;
         r_cfg_rvalid <= 1'b0;
         r_cfg_rdata  <= '0;
         r_cfg_err    <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_idx   <= IdxWidth'(DefaultIdx);
         r_resp_hit   <= 1'b0;
         r_miss_cnt   <= '0;
      end else begin
         if (w_wr_base) r_base[w_rule] <= bus.cfg_wdata_i[AddrWidth-1:0];
         if (w_wr_len)  r_len[w_rule]  <= bus.cfg_wdata_i[AddrWidth-1:0];
         if (w_wr_ctrl) begin
            r_valid[w_rule] <= bus.cfg_wdata_i[0];
            r_idx[w_rule]   <= w_wr_idx;
            r_lock[w_rule]  <= bus.cfg_wdata_i[31];
         end
         r_cfg_rvalid <= bus.cfg_req_i;
         r_cfg_rdata  <= (bus.cfg_req_i && !bus.cfg_we_i) ? w_rdata : '0;
         r_cfg_err    <= bus.cfg_req_i && w_err;
         if (w_acc) begin
            r_resp_valid <= 1'b1;
            r_resp_idx   <= w_idx;
            r_resp_hit   <= w_hit;
         end else if (bus.resp_ready_i) begin
            r_resp_valid <= 1'b0;
         end
         if (w_cnt_clr) begin
            r_miss_cnt <= w_miss ? 32'd1 : 32'd0;
         end else if (w_miss && r_miss_cnt != 32'hFFFF_FFFF) begin
            r_miss_cnt <= r_miss_cnt + 32'd1;
         end
      end
   end

   assign bus.cfg_rvalid_o = r_cfg_rvalid;
   assign bus.cfg_rdata_o  = r_cfg_rdata;
   assign bus.cfg_err_o    = r_cfg_err;
   assign bus.resp_valid_o = r_resp_valid;
   assign bus.resp_idx_o   = r_resp_idx;
   assign bus.resp_hit_o   = r_resp_hit;
   assign bus.miss_cnt_o   = r_miss_cnt;
endmodule

// File: tb/tb_soc_addr_map_cfg.sv
// Directed-vector bench for soc_addr_map_cfg: register map, priority,
// lock, backpressure, wrap-free top rule and miss counter corners.
module tb_soc_addr_map_cfg;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   soc_addr_map_cfg_if #(.AddrWidth(64), .IdxWidth(5)) bus ();

   soc_addr_map_cfg dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   typedef struct {
      bit          lk;
      bit          we;
      logic [7:0]  addr;
      logic [63:0] data;
      logic [63:0] exp_rd;
      bit          exp_err;
      logic [4:0]  exp_idx;
      bit          exp_hit;
   } vec_t;

   vec_t vecs[$];

   logic [63:0] bp_a   [4];
   logic [4:0]  bp_idx [4];
   bit          bp_hit [4];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic C(input bit we, input logic [7:0] a, input logic [63:0] d,
                    input logic [63:0] rd, input bit er);
      vec_t v;
      v = '{lk: 1'b0, we: we, addr: a, data: d, exp_rd: rd, exp_err: er,
            exp_idx: 5'd0, exp_hit: 1'b0};
      vecs.push_back(v);
   endtask

   task automatic L(input logic [63:0] a, input logic [4:0] idx, input bit hit);
      vec_t v;
      v = '{lk: 1'b1, we: 1'b0, addr: 8'd0, data: a, exp_rd: 64'd0, exp_err: 1'b0,
            exp_idx: idx, exp_hit: hit};
      vecs.push_back(v);
   endtask

   task automatic cfg(input bit we, input logic [7:0] a, input logic [63:0] d,
                      output logic [63:0] rd, output logic er);
      @(negedge clk);
      bus.cfg_req_i   = 1'b1;
      bus.cfg_we_i    = we;
      bus.cfg_addr_i  = a;
      bus.cfg_wdata_i = d;
      @(posedge clk);
      #1;
      bus.cfg_req_i = 1'b0;
      bus.cfg_we_i  = 1'b0;
      chk("cfg_rvalid", 64'(bus.cfg_rvalid_o), 64'd1);
      rd = bus.cfg_rdata_o;
      er = bus.cfg_err_o;
   endtask

   task automatic lookup(input logic [63:0] a, output logic [4:0] idx, output logic hit);
      @(negedge clk);
      bus.req_valid_i  = 1'b1;
      bus.req_addr_i   = a;
      bus.resp_ready_i = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid_i = 1'b0;
      chk("resp_valid", 64'(bus.resp_valid_o), 64'd1);
      idx = bus.resp_idx_o;
      hit = bus.resp_hit_o;
   endtask

   initial begin
      logic [63:0] rd;
      logic        er;
      logic [4:0]  idx;
      logic        hit;
      int          sent;
      int          recv;
      bit          stalled;
      bit          acc;
      logic [4:0]  held;

      bus.cfg_req_i    = 1'b0;
      bus.cfg_we_i     = 1'b0;
      bus.cfg_addr_i   = '0;
      bus.cfg_wdata_i  = '0;
      bus.req_valid_i  = 1'b0;
      bus.req_addr_i   = '0;
      bus.resp_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cfg_rvalid", 64'(bus.cfg_rvalid_o), 64'd0);
      chk("rst_cfg_rdata", bus.cfg_rdata_o, 64'd0);
      chk("rst_cfg_err", 64'(bus.cfg_err_o), 64'd0);
      chk("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
      chk("rst_resp_idx", 64'(bus.resp_idx_o), 64'd14);
      chk("rst_resp_hit", 64'(bus.resp_hit_o), 64'd0);
      chk("rst_miss_cnt", 64'(bus.miss_cnt_o), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int a = 0; a < 66; a++) begin
         cfg(1'b0, 8'(a), 64'd0, rd, er);
         chk($sformatf("rst_rd_%0d", a), rd, 64'd0);
         chk($sformatf("rst_err_%0d", a), 64'(er), (a == 65) ? 64'd1 : 64'd0);
      end

      // basic rule, hit/miss boundaries
      C(1, 8'd0, 64'h8000_0000, 0, 0);
      C(1, 8'd1, 64'h2000_0000, 0, 0);
      C(1, 8'd2, 64'h1B, 0, 0);
      C(0, 8'd2, 0, 64'h1B, 0);
      L(64'h8000_0000, 5'd13, 1);
      L(64'h9FFF_FFFF, 5'd13, 1);
      L(64'hA000_0000, 5'd14, 0);
      C(0, 8'd64, 0, 64'd1, 0);
      // overlap priority
      C(1, 8'd12, 64'h1000_0000, 0, 0);
      C(1, 8'd13, 64'h40_0000, 0, 0);
      C(1, 8'd14, 64'h9, 0, 0);
      C(1, 8'd4, 64'h1000_0000, 0, 0);
      C(1, 8'd5, 64'h100_0000, 0, 0);
      C(1, 8'd6, 64'hB, 0, 0);
      L(64'h1000_0010, 5'd5, 1);
      C(1, 8'd6, 64'h0, 0, 0);
      L(64'h1000_0010, 5'd4, 1);
      // lock
      C(1, 8'd10, 64'h8000_000F, 0, 0);
      C(0, 8'd10, 0, 64'h8000_000F, 0);
      C(1, 8'd8, 64'h1234, 0, 1);
      C(0, 8'd8, 0, 64'h0, 0);
      C(1, 8'd9, 64'h55, 0, 1);
      C(1, 8'd10, 64'h0, 0, 1);
      C(0, 8'd10, 0, 64'h8000_000F, 0);
      // illegal idx, reserved, out of map
      C(1, 8'd18, 64'h29, 0, 1);
      C(0, 8'd18, 0, 64'h0, 0);
      C(1, 8'd3, 64'h77, 0, 1);
      C(0, 8'd3, 0, 64'h0, 0);
      C(1, 8'd65, 64'h1, 0, 1);
      C(0, 8'd200, 0, 64'h0, 1);
      // top-of-space rule, zero-length rule never matches
      C(1, 8'd20, 64'hFFFF_FFFF_FFFF_F000, 0, 0);
      C(1, 8'd21, 64'h1000, 0, 0);
      C(1, 8'd22, 64'h5, 0, 0);
      L(64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 1);
      L(64'hFFFF_FFFF_FFFF_EFFF, 5'd14, 0);
      L(64'h0, 5'd14, 0);
      C(0, 8'd64, 0, 64'd3, 0);
      C(1, 8'd64, 64'h0, 0, 0);
      C(0, 8'd64, 0, 64'd0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].lk) begin
            lookup(vecs[i].data, idx, hit);
            chk($sformatf("v%0d_idx", i), 64'(idx), 64'(vecs[i].exp_idx));
            chk($sformatf("v%0d_hit", i), 64'(hit), 64'(vecs[i].exp_hit));
         end else begin
            cfg(vecs[i].we, vecs[i].addr, vecs[i].data, rd, er);
            chk($sformatf("v%0d_rd", i), rd, vecs[i].exp_rd);
            chk($sformatf("v%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
         end
      end

      // backpressure stream
      bp_a[0] = 64'h8000_0000;            bp_idx[0] = 5'd13; bp_hit[0] = 1;
      bp_a[1] = 64'h1000_0010;            bp_idx[1] = 5'd4;  bp_hit[1] = 1;
      bp_a[2] = 64'h5;                    bp_idx[2] = 5'd14; bp_hit[2] = 0;
      bp_a[3] = 64'hFFFF_FFFF_FFFF_F800;  bp_idx[3] = 5'd2;  bp_hit[3] = 1;
      sent = 0;
      recv = 0;
      stalled = 0;
      held = '0;
      for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
         @(negedge clk);
         bus.resp_ready_i = !(cyc == 2 || cyc == 3);
         bus.req_valid_i  = sent < 4;
         bus.req_addr_i   = (sent < 4) ? bp_a[sent] : 64'd0;
         #1;
         if (stalled) chk("bp_stable", 64'(bus.resp_idx_o), 64'(held));
         stalled = 0;
         if (bus.resp_valid_o) begin
            if (bus.resp_ready_i) begin
               chk($sformatf("bp_idx_%0d", recv), 64'(bus.resp_idx_o), 64'(bp_idx[recv]));
               chk($sformatf("bp_hit_%0d", recv), 64'(bus.resp_hit_o), 64'(bp_hit[recv]));
               recv++;
            end else begin
               stalled = 1;
               held = bus.resp_idx_o;
            end
         end
         acc = bus.req_valid_i && bus.req_ready_o;
         @(posedge clk);
         if (acc) sent++;
      end
      @(negedge clk);
      bus.req_valid_i  = 1'b0;
      bus.resp_ready_i = 1'b1;
      chk("bp_count", 64'(recv), 64'd4);
      chk("bp_sent", 64'(sent), 64'd4);

      // lookup sees the pre-write table in the write cycle
      cfg(1'b1, 8'd24, 64'h7000, rd, er);
      cfg(1'b1, 8'd25, 64'h10, rd, er);
      @(negedge clk);
      bus.cfg_req_i   = 1'b1;
      bus.cfg_we_i    = 1'b1;
      bus.cfg_addr_i  = 8'd26;
      bus.cfg_wdata_i = 64'h7;
      bus.req_valid_i = 1'b1;
      bus.req_addr_i  = 64'h7000;
      @(posedge clk);
      #1;
      bus.cfg_req_i   = 1'b0;
      bus.cfg_we_i    = 1'b0;
      bus.req_valid_i = 1'b0;
      chk("same_cyc_idx", 64'(bus.resp_idx_o), 64'd14);
      chk("same_cyc_hit", 64'(bus.resp_hit_o), 64'd0);
      lookup(64'h7000, idx, hit);
      chk("after_wr_idx", 64'(idx), 64'd3);
      chk("after_wr_hit", 64'(hit), 64'd1);

      // counter clear coinciding with a miss
      @(negedge clk);
      bus.cfg_req_i   = 1'b1;
      bus.cfg_we_i    = 1'b1;
      bus.cfg_addr_i  = 8'd64;
      bus.cfg_wdata_i = 64'h0;
      bus.req_valid_i = 1'b1;
      bus.req_addr_i  = 64'h5;
      @(posedge clk);
      #1;
      bus.cfg_req_i   = 1'b0;
      bus.cfg_we_i    = 1'b0;
      bus.req_valid_i = 1'b0;
      chk("clr_and_miss", 64'(bus.miss_cnt_o), 64'd1);

      // saturation
      @(negedge clk);
      force dut.r_miss_cnt = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      release dut.r_miss_cnt;
      @(negedge clk);
      chk("sat_preload", 64'(bus.miss_cnt_o), 64'hFFFF_FFFF);
      lookup(64'h5, idx, hit);
      chk("sat_miss_hit", 64'(hit), 64'd0);
      @(negedge clk);
      chk("sat_hold", 64'(bus.miss_cnt_o), 64'hFFFF_FFFF);

      // reset drops a pending lookup and config response
      @(negedge clk);
      bus.resp_ready_i = 1'b0;
      bus.req_valid_i  = 1'b1;
      bus.req_addr_i   = 64'h8000_0000;
      @(posedge clk);
      #1;
      bus.req_valid_i = 1'b0;
      chk("pend_valid", 64'(bus.resp_valid_o), 64'd1);
      @(negedge clk);
      rst = 1'b1;
      bus.cfg_req_i  = 1'b1;
      bus.cfg_addr_i = 8'd2;
      @(posedge clk);
      #1;
      bus.cfg_req_i = 1'b0;
      chk("mid_rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
      chk("mid_rst_resp_idx", 64'(bus.resp_idx_o), 64'd14);
      chk("mid_rst_cfg_rvalid", 64'(bus.cfg_rvalid_o), 64'd0);
      chk("mid_rst_miss_cnt", 64'(bus.miss_cnt_o), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.resp_ready_i = 1'b1;
      cfg(1'b0, 8'd10, 64'd0, rd, er);
      chk("rst_clears_lock", rd, 64'd0);
      cfg(1'b1, 8'd8, 64'h1234, rd, er);
      chk("rst_unlock_err", 64'(er), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
